// File: rtl/ex_muldiv.sv
// RV32M/RV64M multiply/divide unit: iterative shift-add multiply (or single-cycle),
// restoring divide retiring DIV_BITS_PER_CYCLE quotient bits per cycle.
module ex_muldiv #(
  parameter int XLEN               = 32,
  parameter int DIV_BITS_PER_CYCLE = 1,
  parameter int MUL_MODE           = 0
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_src1,
  input  logic [XLEN-1:0] req_src2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN / DIV_BITS_PER_CYCLE - 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   a_q, a_d, hi_q, hi_d, lo_q, lo_d, result_q, result_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              sgn1, sgn2, s1_neg, s2_neg;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2*XLEN-1:0] ext1, ext2, prod_fast;
  logic [XLEN:0]     msum, shifted;
  logic [XLEN-1:0]   rem_t, quo_t, it_hi, it_lo, q_s, r_s, final_res;
  logic [2*XLEN-1:0] prod_s;
  logic              last;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    a_d      = a_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    req_ready = (state_q == IDLE) && !flush;

    // Operand signedness: MULH/DIV/REM both signed, MULHSU only rs1.
    sgn1   = (req_op == 3'd1) || (req_op == 3'd2) || (req_op == 3'd4) || (req_op == 3'd6);
    sgn2   = (req_op == 3'd1) || (req_op == 3'd4) || (req_op == 3'd6);
    s1_neg = sgn1 && req_src1[XLEN-1];
    s2_neg = sgn2 && req_src2[XLEN-1];
    mag1   = s1_neg ? -req_src1 : req_src1;
    mag2   = s2_neg ? -req_src2 : req_src2;
    ext1      = {{XLEN{s1_neg}}, req_src1};
    ext2      = {{XLEN{s2_neg}}, req_src2};
    prod_fast = ext1 * ext2;

    // One shift-add multiply step: {hi,lo} shifts right as multiplier bits are consumed.
    msum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? a_q : {XLEN{1'b0}})};

    rem_t   = hi_q;
    quo_t   = lo_q;
    shifted = '0;
    for (int i = 0; i < DIV_BITS_PER_CYCLE; i++) begin
      shifted = {rem_t, quo_t[XLEN-1]};
      if (shifted >= {1'b0, a_q}) begin
        rem_t = shifted[XLEN-1:0] - a_q;
        quo_t = {quo_t[XLEN-2:0], 1'b1};
      end else begin
        rem_t = shifted[XLEN-1:0];
        quo_t = {quo_t[XLEN-2:0], 1'b0};
      end
    end

    it_hi = op_q[2] ? rem_t : msum[XLEN:1];
    it_lo = op_q[2] ? quo_t : {msum[0], lo_q[XLEN-1:1]};

    prod_s = neg_q ? -{it_hi, it_lo} : {it_hi, it_lo};
    q_s    = neg_q ? -it_lo : it_lo;
    r_s    = neg_q ? -it_hi : it_hi;
    if (op_q[2])
      final_res = op_q[1] ? r_s : q_s;
    else
      final_res = (op_q == 3'd0) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    last = (cnt_q == (op_q[2] ? DIV_LAST : MUL_LAST));

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d  = req_op;
          neg_d = (req_op[2] && req_op[1]) ? s1_neg : (s1_neg ^ s2_neg);
          a_d   = req_op[2] ? mag2 : mag1;
          lo_d  = req_op[2] ? mag1 : mag2;
          hi_d  = '0;
          cnt_d = '0;
          if (req_op[2] && (req_src2 == '0)) begin
            result_d = req_op[1] ? req_src1 : '1;
            state_d  = DONE;
          end else if (req_op[2] && !req_op[0] && (req_src1 == MIN_NEG) && (req_src2 == '1)) begin
            result_d = req_op[1] ? '0 : req_src1;
            state_d  = DONE;
          end else if (!req_op[2] && (MUL_MODE == 1)) begin
            result_d = (req_op == 3'd0) ? prod_fast[XLEN-1:0] : prod_fast[2*XLEN-1:XLEN];
            state_d  = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        hi_d  = it_hi;
        lo_d  = it_lo;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          result_d = final_res;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  assign resp_valid  = (state_q == DONE);
  assign resp_result = result_q;
  assign busy        = (state_q != IDLE);
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed + random checks of ex_muldiv across three parameter sets sharing one clock.
module tb_ex_muldiv;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [2:0]  req_valid_v = '0, flush_v = '0, resp_ready_v = '0;
  logic [2:0]  req_op = '0;
  logic [63:0] src1 = '0, src2 = '0;
  int          sel = 0;
  int          n_pass = 0, n_total = 0;

  logic [2:0]  rdy_v, rv_v, busy_v;
  logic [31:0] res_a, res_b;
  logic [63:0] res_c;
  logic        rdy, rv, bsy;
  logic [63:0] res;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .DIV_BITS_PER_CYCLE(1), .MUL_MODE(0)) u_a (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid_v[0]), .req_ready(rdy_v[0]),
    .req_op(req_op), .req_src1(src1[31:0]), .req_src2(src2[31:0]), .flush(flush_v[0]),
    .resp_valid(rv_v[0]), .resp_ready(resp_ready_v[0]), .resp_result(res_a), .busy(busy_v[0]));
  ex_muldiv #(.XLEN(32), .DIV_BITS_PER_CYCLE(1), .MUL_MODE(1)) u_b (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid_v[1]), .req_ready(rdy_v[1]),
    .req_op(req_op), .req_src1(src1[31:0]), .req_src2(src2[31:0]), .flush(flush_v[1]),
    .resp_valid(rv_v[1]), .resp_ready(resp_ready_v[1]), .resp_result(res_b), .busy(busy_v[1]));
  ex_muldiv #(.XLEN(64), .DIV_BITS_PER_CYCLE(4), .MUL_MODE(0)) u_c (
    .clk(clk), .rst_b(rst_b), .req_valid(req_valid_v[2]), .req_ready(rdy_v[2]),
    .req_op(req_op), .req_src1(src1), .req_src2(src2), .flush(flush_v[2]),
    .resp_valid(rv_v[2]), .resp_ready(resp_ready_v[2]), .resp_result(res_c), .busy(busy_v[2]));

  always_comb begin
    rdy = rdy_v[sel];
    rv  = rv_v[sel];
    bsy = busy_v[sel];
    case (sel)
      0:       res = {32'h0, res_a};
      1:       res = {32'h0, res_b};
      default: res = res_c;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Issue one request, measure edges from accept to resp_valid, optionally stall the response.
  task automatic do_vec(input int s, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    sel = s;
    req_op = op; src1 = a; src2 = b;
    req_valid_v[s] = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      req_valid_v[s] = 1'b0;
      lat++;
    end while (!rv && lat < 100);
    $display("op=%0d inst=%0d src1=%h src2=%h result=%h latency=%0d", op, s, a, b, res, lat);
    check_eq("result", res, exp);
    check_eq("latency", 64'(lat), 64'(exp_lat));
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check_eq("hold_valid", {63'h0, rv}, 64'h1);
      check_eq("hold_result", res, exp);
    end
    resp_ready_v[s] = 1'b1;
    @(posedge clk); #1;
    resp_ready_v[s] = 1'b0;
    if (hold > 0) begin
      check_eq("post_hold_busy", {63'h0, bsy}, 64'h0);
      check_eq("post_hold_ready", {63'h0, rdy}, 64'h1);
    end
  endtask

  initial begin
    int rv_seen;
    logic [63:0] ra, rb;
    #1;
    sel = 0;
    check_eq("rst_valid", {63'h0, rv}, 64'h0);
    check_eq("rst_busy", {63'h0, bsy}, 64'h0);
    check_eq("rst_result", res, 64'h0);
    @(negedge clk); rst_b = 1'b1; #1;
    check_eq("rst_ready", {63'h0, rdy}, 64'h1);

    // Signed divide / remainder
    do_vec(0, 3'd4, 64'h7,        64'hFFFFFFFE, 64'hFFFFFFFD, 33, 0);
    do_vec(0, 3'd6, 64'h7,        64'hFFFFFFFE, 64'h1,        33, 0);
    do_vec(0, 3'd4, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 33, 0);
    do_vec(0, 3'd6, 64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 33, 0);
    do_vec(0, 3'd5, 64'd100,      64'd7,        64'd14,       33, 0);
    do_vec(0, 3'd7, 64'd100,      64'd7,        64'd2,        33, 0);
    // Divide by zero and signed overflow
    do_vec(0, 3'd5, 64'h5,        64'h0,        64'hFFFFFFFF, 1, 0);
    do_vec(0, 3'd7, 64'h5,        64'h0,        64'h5,        1, 0);
    do_vec(0, 3'd4, 64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1, 0);
    do_vec(0, 3'd6, 64'h80000000, 64'hFFFFFFFF, 64'h0,        1, 0);
    // Multiplies, iterative and single-cycle
    for (int m = 0; m < 2; m++) begin
      do_vec(m, 3'd0, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h1,        m ? 1 : 33, 0);
      do_vec(m, 3'd1, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h0,        m ? 1 : 33, 0);
      do_vec(m, 3'd3, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, m ? 1 : 33, 0);
      do_vec(m, 3'd2, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, m ? 1 : 33, 0);
      do_vec(m, 3'd0, 64'd6,        64'd7,        64'd42,       m ? 1 : 33, 0);
    end

    // Stalled response: result held for 5 cycles
    do_vec(0, 3'd5, 64'd100, 64'd7, 64'd14, 33, 5);

    // Flush during CALC cycle 10
    @(negedge clk);
    sel = 0; req_op = 3'd4; src1 = 64'd100; src2 = 64'hFFFFFFF9;
    req_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    req_valid_v[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2 flush_v[0] = 1'b1;
    @(posedge clk); #1;
    flush_v[0] = 1'b0;
    check_eq("flush_busy", {63'h0, bsy}, 64'h0);
    check_eq("flush_valid", {63'h0, rv}, 64'h0);
    rv_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rv) rv_seen++;
    end
    check_eq("flush_no_resp", 64'(rv_seen), 64'h0);
    do_vec(0, 3'd4, 64'd100, 64'hFFFFFFF9, 64'hFFFFFFF2, 33, 0);
    do_vec(0, 3'd6, 64'd100, 64'hFFFFFFF9, 64'h2,        33, 0);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    flush_v[0] = 1'b1; req_valid_v[0] = 1'b1;
    #1 check_eq("flush_idle_ready", {63'h0, rdy}, 64'h0);
    @(posedge clk); #1;
    check_eq("flush_idle_busy", {63'h0, bsy}, 64'h0);
    flush_v[0] = 1'b0; req_valid_v[0] = 1'b0;

    // Asynchronous reset mid-CALC (previous result 2 is nonzero)
    @(negedge clk);
    req_op = 3'd0; src1 = 64'd6; src2 = 64'd7;
    req_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    req_valid_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_b = 1'b0;
    #1;
    check_eq("arst_valid", {63'h0, rv}, 64'h0);
    check_eq("arst_busy", {63'h0, bsy}, 64'h0);
    check_eq("arst_result", res, 64'h0);
    @(negedge clk); rst_b = 1'b1; #1;
    check_eq("arst_ready", {63'h0, rdy}, 64'h1);
    do_vec(0, 3'd0, 64'd6, 64'd7, 64'd42, 33, 0);

    // XLEN=64, 4 bits/cycle random DIVU
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom} >> $urandom_range(0, 63);
      if (rb == 64'h0) rb = 64'h1;
      do_vec(2, 3'd5, ra, rb, ra / rb, 17, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 Parameter DIV_BITS_PER_CYCLE, default 1, quotient bits retired per CALC cycle; legal values 1, 2, 4.
REQ-003 Parameter MUL_MODE, default 0: 0 = iterative shift-add multiply; 1 = single-cycle multiply.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst_b  input  1  reset; asynchronous assertion, active-low.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  unit can accept a request.
REQ-008 req_op  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-009 req_src1  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-010 req_src2  input  XLEN  rs2 operand (multiplier/divisor).
REQ-011 flush  input  1  kill in-flight operation (pipeline flush).
REQ-012 resp_valid  output  1  result available.
REQ-013 resp_ready  input  1  consumer accepts result.
REQ-014 resp_result  output  XLEN  result.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM states: IDLE, CALC, DONE; no other states are reachable.
REQ-017 req_ready = (state == IDLE) & ~flush; handshake when req_valid & req_ready; operands and op captured on that edge.
REQ-018 IDLE -> CALC on handshake for a normal op; IDLE -> DONE on handshake for special cases (REQ-023, REQ-024) and for multiply when MUL_MODE=1.
REQ-019 N = XLEN/DIV_BITS_PER_CYCLE for divide; N = XLEN for multiply with MUL_MODE=0; CALC lasts exactly N cycles, then -> DONE with the sign-corrected result registered.
REQ-020 Latency: resp_valid rises N+1 edges after the accepting edge for CALC ops; 1 edge after for direct-to-DONE ops.
REQ-021 DONE: resp_valid=1; resp_result stable until resp_ready; resp_valid & resp_ready -> IDLE on the same edge; no new request accepted in that cycle.
REQ-022 Signed ops operate on magnitudes; quotient negated when operand signs differ; remainder takes dividend sign; MULH signed x signed, MULHSU signed rs1 x unsigned rs2, MULHU unsigned x unsigned; MUL returns low XLEN bits, MULH* return high XLEN bits of the 2*XLEN product.
REQ-023 Divide by zero: DIV/DIVU -> all ones; REM/REMU -> src1; no exception raised.
REQ-024 Signed overflow (src1 = -2^(XLEN-1), src2 = -1): DIV -> src1; REM -> 0.
REQ-025 flush in any state: next state IDLE, resp_valid 0 next cycle, in-flight result discarded; flush outranks a same-cycle resp handshake and blocks acceptance.
REQ-026 resp_ready held high in IDLE/CALC has no effect.
REQ-027 Back-to-back ops: earliest next acceptance is the cycle after DONE exits.

Reset
REQ-028 rst_b low asynchronously forces state IDLE, resp_valid 0, resp_result 0, busy 0, internal accumulators 0, including mid-CALC.
REQ-029 After rst_b deasserts, req_ready = 1 on the first cycle (flush low).

Verification
REQ-030 XLEN=32, DBPC=1: DIV 7 / -2 -> 0xFFFFFFFD; REM -> 1; DIV -7 / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; resp_valid exactly 33 edges after accept.
REQ-031 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each 1 edge after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-032 src1 = src2 = 0xFFFFFFFF: MUL -> 1; MULH -> 0; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF; checked with MUL_MODE 0 (33 edges) and 1 (1 edge).
REQ-033 DONE with resp_ready low 5 cycles -> resp_valid and resp_result stable; then resp_ready high -> IDLE next edge, req_ready 1.
REQ-034 flush in CALC cycle 10 -> IDLE, no resp_valid pulse; next request completes with correct result; flush with req_valid high in IDLE -> no acceptance.
REQ-035 rst_b low mid-CALC (asynchronous, between edges) -> outputs at reset values immediately; DBPC=4, XLEN=64 DIVU random 1000-vector check against reference model, 17-edge latency.
